fft_peak_tracker: RTL and testbench
===================================

FFT_PEAK_TRACKER -- requirements
Module: fft_peak_tracker

Interface
REQ-001 SHALL have parameter FRAMES, default 4, giving the number of magnitude frames summed per decision (legal range 1..256).
REQ-002 SHALL have parameter MAG_W, default 8, giving the width of each input bin magnitude.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a magnitude frame is present on X0_mag..X3_mag.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a frame this cycle.
REQ-007 SHALL have ports X0_mag, X1_mag, X2_mag, X3_mag, input, MAG_W each: bin magnitudes 0..3 from the magnitude stage.
REQ-008 SHALL have port out_valid, output, 1 bit: a peak result is held on peak_bin/peak_sum.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port peak_bin, output, 2 bits: index of the bin with the largest summed magnitude.
REQ-011 SHALL have port peak_sum, output, ACC_W = MAG_W + clog2(FRAMES) (minimum MAG_W+1) bits: that bin's summed magnitude.

Function
REQ-012 SHALL implement an FSM with states ACCUM, SCAN and HOLD.
REQ-013 SHALL count a frame as accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 SHALL drive in_ready=1 only in ACCUM.
REQ-015 SHALL, in ACCUM, add each accepted Xk_mag (zero-extended) into per-bin accumulator acc[k] and increment frame counter fcnt.
REQ-016 SHALL move from ACCUM to SCAN on the edge that accepts frame number FRAMES, with that frame included in the sums.
REQ-017 SHALL, in SCAN, examine one bin per cycle in index order 0,1,2,3, taking exactly 4 cycles.
REQ-018 SHALL update the running best only when acc[k] is strictly greater than the current best, so on ties the lowest index wins.
REQ-019 SHALL load bin 0 unconditionally as the initial best.
REQ-020 SHALL move to HOLD after bin 3 is examined and assert out_valid, with out_valid first high 5 cycles after the final accepting edge.
REQ-021 SHALL, in HOLD, keep peak_bin and peak_sum stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on the out_valid and out_ready edge, clear all acc[k] and fcnt, deassert out_valid and return to ACCUM.
REQ-023 SHALL ignore in_valid outside ACCUM, with no sample lost or double-counted.
REQ-024 SHALL ignore out_ready outside HOLD.
REQ-025 SHALL never overflow an accumulator, with ACC_W sized for FRAMES × (2^MAG_W−1).
REQ-026 SHALL, when FRAMES=1, take a single accepted frame directly into SCAN.
REQ-027 SHALL hold peak_bin and peak_sum at their last values after the handshake until the next HOLD.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-SCAN or HOLD, immediately set state=ACCUM, acc[0..3]=0, fcnt=0, out_valid=0, peak_bin=0 and peak_sum=0.
REQ-029 SHALL hold in_ready=0 while rst=1, and in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-030 SHALL discard any partial accumulation on reset, producing no result output.

Structure
REQ-031 SHALL take BIN_COUNT=4, default MAG_W=8 and the FSM state enum from shared package fft_pkg.
REQ-032 SHALL be a single module with no sub-modules, with the accumulator array and scan comparator inline.

Verification
REQ-033 SHALL verify: FRAMES=4, four frames of X=(10,20,30,5), out_ready=1 -> out_valid 5 cycles after 4th accept, peak_bin=2, peak_sum=120.
REQ-034 SHALL verify a tie: frames X=(50,50,10,50)×4 -> peak_bin=0, peak_sum=200.
REQ-035 SHALL verify backpressure: out_ready=0 for 10 cycles after out_valid, in_valid=1 throughout -> in_ready=0, result stable, no extra frame counted; next decision needs 4 fresh frames.
REQ-036 SHALL verify full scale: four frames of (255,255,255,255) -> peak_sum=1020 with no wrap, peak_bin=0.
REQ-037 SHALL verify reset mid-SCAN, asserted during SCAN cycle 2 -> out_valid never asserts, and the next 4 frames X=(1,2,3,9) give peak_bin=3, peak_sum=36.
REQ-038 SHALL verify gapped input: in_valid toggling 1,0,0,1,... over 4 accepts with X=(0,7,0,0) -> peak_bin=1, peak_sum=28.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT peak tracker.
//   BIN_COUNT     - number of magnitude bins per frame
//   MAG_W_DEFAULT - default width of one bin magnitude
//   state_t       - tracker FSM states
//   acc_width()   - accumulator width for a given magnitude width and frame count
package fft_pkg;

   localparam int BIN_COUNT     = 4;
   localparam int MAG_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Enough headroom for frames * (2^mag_w - 1); never narrower than mag_w+1.
   function automatic int acc_width(input int mag_w, input int frames);
      int w;
      w = mag_w + $clog2(frames);
      if (frames < 2) w = mag_w + 1;
      return w;
   endfunction

endpackage

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: sums FRAMES magnitude frames per bin, then scans the four
// sums and reports the bin with the largest total (lowest index wins ties).
//   clk                 - clock, rising edge
//   rst                 - asynchronous active-high reset
//   in_valid / in_ready - frame handshake; ready only while accumulating
//   X0_mag..X3_mag      - bin magnitudes of the current frame
//   out_valid/out_ready - result handshake; result held until accepted
//   peak_bin, peak_sum  - winning bin index and its summed magnitude
module fft_peak_tracker
   import fft_pkg::*;
#(
   parameter  int FRAMES = 4,
   parameter  int MAG_W  = MAG_W_DEFAULT,
   localparam int ACC_W  = acc_width(MAG_W, FRAMES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MAG_W-1:0] X0_mag,
   input  logic [MAG_W-1:0] X1_mag,
   input  logic [MAG_W-1:0] X2_mag,
   input  logic [MAG_W-1:0] X3_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       peak_bin,
   output logic [ACC_W-1:0] peak_sum
);

   localparam int                FCNT_W    = $clog2(FRAMES + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES - 1);

   state_t             state;
   logic [ACC_W-1:0]   acc [BIN_COUNT];
   logic [FCNT_W-1:0]  fcnt;
   logic [1:0]         sidx;
   logic [1:0]         best_bin;
   logic [ACC_W-1:0]   best_sum;
   logic [MAG_W-1:0]   mag [BIN_COUNT];
   logic               accept;

   assign mag[0] = X0_mag;
   assign mag[1] = X1_mag;
   assign mag[2] = X2_mag;
   assign mag[3] = X3_mag;

   // Gated by rst so the block reports not-ready while held in reset and
   // ready immediately once reset releases.
   assign in_ready = (state == ST_ACCUM) && !rst;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_ACCUM;
         for (int k = 0; k < BIN_COUNT; k++) acc[k] <= '0;
         fcnt      <= '0;
         sidx      <= '0;
         best_bin  <= '0;
         best_sum  <= '0;
         out_valid <= 1'b0;
         peak_bin  <= '0;
         peak_sum  <= '0;
      end else begin
         case (state)
            // Accumulate accepted frames; the last one is included before scanning.
            ST_ACCUM: begin
               if (accept) begin
                  for (int k = 0; k < BIN_COUNT; k++)
                     acc[k] <= acc[k] + ACC_W'(mag[k]);
                  fcnt <= fcnt + 1'b1;
                  if (fcnt == FCNT_LAST) begin
                     state <= ST_SCAN;
                     sidx  <= '0;
                  end
               end
            end
            // One bin per cycle; bin 0 seeds the best, later bins must be strictly larger.
            ST_SCAN: begin
               if (sidx == 2'd0 || acc[sidx] > best_sum) begin
                  best_sum <= acc[sidx];
                  best_bin <= sidx;
               end
               sidx <= sidx + 1'b1;
               if (sidx == 2'd3) state <= ST_HOLD;
            end
            // Publish the scan result, then wait for the consumer.
            ST_HOLD: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  peak_bin  <= best_bin;
                  peak_sum  <= best_sum;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  for (int k = 0; k < BIN_COUNT; k++) acc[k] <= '0;
                  fcnt      <= '0;
                  state     <= ST_ACCUM;
               end
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_peak_tracker.sv
// tb_fft_peak_tracker: scoreboard bench for fft_peak_tracker (FRAMES=4, MAG_W=8).
module tb_fft_peak_tracker;

   localparam int FRAMES = 4;
   localparam int MAG_W  = 8;
   localparam int ACC_W  = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [MAG_W-1:0] X0_mag, X1_mag, X2_mag, X3_mag;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       peak_bin;
   logic [ACC_W-1:0] peak_sum;

   fft_peak_tracker #(.FRAMES(FRAMES), .MAG_W(MAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .X0_mag(X0_mag), .X1_mag(X1_mag), .X2_mag(X2_mag), .X3_mag(X3_mag),
      .out_valid(out_valid), .out_ready(out_ready),
      .peak_bin(peak_bin), .peak_sum(peak_sum)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]       bin;
      logic [ACC_W-1:0] sum;
   } res_t;

   res_t sb_q[$];
   res_t exp_r;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc          = 0;
   int   ov_cnt       = 0;
   int   m_acc[4];
   int   m_cnt        = 0;
   int   acc_cyc;
   int   lat;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare each delivered result against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) ov_cnt <= ov_cnt + 1;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
         else begin
            exp_r = sb_q.pop_front();
            check("sb_bin", 32'(peak_bin), 32'(exp_r.bin));
            check("sb_sum", 32'(peak_sum), 32'(exp_r.sum));
         end
      end
   end

   task automatic model_clear();
      for (int k = 0; k < 4; k++) m_acc[k] = 0;
      m_cnt = 0;
   endtask

   task automatic model_add(input int a, input int b, input int c, input int d);
      res_t r;
      int   bi, bs;
      m_acc[0] += a; m_acc[1] += b; m_acc[2] += c; m_acc[3] += d;
      m_cnt++;
      if (m_cnt == FRAMES) begin
         bi = 0; bs = m_acc[0];
         for (int k = 1; k < 4; k++)
            if (m_acc[k] > bs) begin bi = k; bs = m_acc[k]; end
         r.bin = 2'(bi);
         r.sum = ACC_W'(bs);
         sb_q.push_back(r);
         model_clear();
      end
   endtask

   task automatic send(input int a, input int b, input int c, input int d, output int when);
      bit ok = 0;
      X0_mag = MAG_W'(a); X1_mag = MAG_W'(b); X2_mag = MAG_W'(c); X3_mag = MAG_W'(d);
      in_valid = 1'b1;
      when = -1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            ok = 1;
         end
      end
      #1;
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      else begin
         model_add(a, b, c, d);
         when = cyc;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns at the negedge where out_valid is first seen high.
   task automatic wait_valid(input int start, output int l);
      bit found = 0;
      l = -1;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (out_valid) begin found = 1; l = cyc - start; end
      end
      if (!found) check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      X0_mag = '0; X1_mag = '0; X2_mag = '0; X3_mag = '0;
      model_clear();

      // Reset state
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_peak_bin", 32'(peak_bin), 32'd0);
      check("rst_peak_sum", 32'(peak_sum), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_in_ready", 32'(in_ready), 32'd1);
      idle(1);

      // Basic: peak on bin 2, latency 5
      out_ready = 1'b1;
      for (int f = 0; f < 4; f++) send(10, 20, 30, 5, acc_cyc);
      wait_valid(acc_cyc, lat);
      check("basic_latency", 32'(lat), 32'd5);
      check("basic_bin", 32'(peak_bin), 32'd2);
      check("basic_sum", 32'(peak_sum), 32'd120);
      idle(3);
      check("basic_done_in_ready", 32'(in_ready), 32'd1);

      // Tie: lowest index wins
      for (int f = 0; f < 4; f++) send(50, 50, 10, 50, acc_cyc);
      wait_valid(acc_cyc, lat);
      check("tie_bin", 32'(peak_bin), 32'd0);
      check("tie_sum", 32'(peak_sum), 32'd200);
      idle(3);

      // Backpressure
      out_ready = 1'b0;
      for (int f = 0; f < 4; f++) send(10, 20, 30, 5, acc_cyc);
      wait_valid(acc_cyc, lat);
      @(posedge clk); #1;
      in_valid = 1'b1;
      X0_mag = 8'd99; X1_mag = 8'd99; X2_mag = 8'd99; X3_mag = 8'd99;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_bin", 32'(peak_bin), 32'd2);
         check("bp_sum", 32'(peak_sum), 32'd120);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(2);
      check("bp_released", 32'(out_valid), 32'd0);
      for (int f = 0; f < 3; f++) send(3, 1, 4, 1, acc_cyc);
      idle(8);
      check("bp_no_early_result", 32'(out_valid), 32'd0);
      send(3, 1, 4, 1, acc_cyc);
      wait_valid(acc_cyc, lat);
      check("bp_next_bin", 32'(peak_bin), 32'd2);
      check("bp_next_sum", 32'(peak_sum), 32'd16);
      idle(3);

      // Full scale
      for (int f = 0; f < 4; f++) send(255, 255, 255, 255, acc_cyc);
      wait_valid(acc_cyc, lat);
      check("full_bin", 32'(peak_bin), 32'd0);
      check("full_sum", 32'(peak_sum), 32'd1020);
      idle(3);

      // Reset during SCAN cycle 2
      for (int f = 0; f < 4; f++) send(7, 7, 40, 7, acc_cyc);
      @(posedge clk); #1;
      rst = 1'b1;
      sb_q.delete();
      model_clear();
      @(negedge clk);
      check("midscan_rst_in_ready", 32'(in_ready), 32'd0);
      check("midscan_rst_sum", 32'(peak_sum), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ov_cnt = 0;
      @(negedge clk);
      check("midscan_release_in_ready", 32'(in_ready), 32'd1);
      idle(20);
      check("midscan_no_output", 32'(ov_cnt), 32'd0);
      for (int f = 0; f < 4; f++) send(1, 2, 3, 9, acc_cyc);
      wait_valid(acc_cyc, lat);
      check("after_rst_bin", 32'(peak_bin), 32'd3);
      check("after_rst_sum", 32'(peak_sum), 32'd36);
      idle(3);

      // Gapped input: in_valid 1,0,0,1,...
      for (int f = 0; f < 4; f++) begin
         send(0, 7, 0, 0, acc_cyc);
         if (f < 3) idle(2);
      end
      wait_valid(acc_cyc, lat);
      check("gap_latency", 32'(lat), 32'd5);
      check("gap_bin", 32'(peak_bin), 32'd1);
      check("gap_sum", 32'(peak_sum), 32'd28);
      idle(4);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
